// File: rtl/wish_rr_arbiter_if.sv
// Wishbone classic bundle between N stream sources, the arbiter and one sink.
// The slave modport is the arbiter's view; the master modport is the environment's view.
// Port names keep the Wishbone _i/_o affixes as seen from the arbiter.
interface wish_rr_arbiter_if #(
   parameter int N          = 2,
   parameter int DATA_WIDTH = 32,
   parameter int TGC_WIDTH  = 2
);
   logic [N-1:0]            m_cyc_i;
   logic [N-1:0]            m_stb_i;
   logic [N*DATA_WIDTH-1:0] m_dat_i;
   logic [N*TGC_WIDTH-1:0]  m_tgc_i;
   logic [N-1:0]            m_ack_o;
   logic                    s_cyc_o;
   logic                    s_stb_o;
   logic [DATA_WIDTH-1:0]   s_dat_o;
   logic [TGC_WIDTH-1:0]    s_tgc_o;
   logic                    s_ack_i;

   modport slave (
      input  m_cyc_i, m_stb_i, m_dat_i, m_tgc_i, s_ack_i,
      output m_ack_o, s_cyc_o, s_stb_o, s_dat_o, s_tgc_o
   );

   modport master (
      output m_cyc_i, m_stb_i, m_dat_i, m_tgc_i, s_ack_i,
      input  m_ack_o, s_cyc_o, s_stb_o, s_dat_o, s_tgc_o
   );
endinterface

// File: rtl/wish_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic sink among N sources, grant held per cyc.
// Latency: grant registered one edge after cyc request; data/ack paths combinational from grant.
// Backpressure: sink ack routed to granted source only; stalled holders are revoked by a watchdog.
module wish_rr_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int TGC_WIDTH  = 2,
   parameter int N          = 2,
   parameter int TIMEOUT    = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   wish_rr_arbiter_if.slave bus,
   output logic [N-1:0]  gnt_o,
   output logic          err_o
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(TIMEOUT + 2);

   typedef enum logic {IDLE, GRANTED} state_t;

   state_t          state, state_nx;
   logic [PW-1:0]   g, g_nx;
   logic [PW-1:0]   ptr, ptr_nx;
   logic [PW-1:0]   win, scan_idx;
   logic [N-1:0]    mask, mask_nx;
   logic [N-1:0]    gnt_nx, elig;
   logic [CW-1:0]   stall_cnt, stall_nx;
   logic            err_nx, found, arb;
   logic            holder_cyc, holder_stb, timeout_hit;

   assign holder_cyc = bus.m_cyc_i[g];
   assign holder_stb = bus.m_stb_i[g];

   // A holder that keeps cyc up without strobing for TIMEOUT cycles is revoked on this edge;
   // a holder dropping cyc in the same cycle is a normal release instead.
   assign timeout_hit = (TIMEOUT != 0) && (state == GRANTED) && holder_cyc && !holder_stb &&
                        (stall_cnt == CW'(TIMEOUT - 1));

   // State register: grant, pointer, mask, watchdog counter and error pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         g         <= '0;
         ptr       <= '0;
         mask      <= '0;
         stall_cnt <= '0;
         gnt_o     <= '0;
         err_o     <= 1'b0;
      end else begin
         state     <= state_nx;
         g         <= g_nx;
         ptr       <= ptr_nx;
         mask      <= mask_nx;
         stall_cnt <= stall_nx;
         gnt_o     <= gnt_nx;
         err_o     <= err_nx;
      end
   end

   // Next state: round-robin scan from ptr, handoff without bubble, watchdog revoke.
   always_comb begin
      state_nx = state;
      g_nx     = g;
      ptr_nx   = ptr;
      gnt_nx   = gnt_o;
      stall_nx = stall_cnt;
      err_nx   = timeout_hit;
      found    = 1'b0;
      win      = '0;
      scan_idx = '0;

      // Masks are sticky only while the revoked source keeps cyc asserted.
      mask_nx = mask & bus.m_cyc_i;
      if (timeout_hit) mask_nx[g] = 1'b1;

      // The revoked holder must not win the re-arbitration on its own revoke edge.
      elig = bus.m_cyc_i & ~mask;
      if (timeout_hit) elig[g] = 1'b0;

      // ptr already points past the last winner, so a released holder scans last.
      for (int k = 0; k < N; k++) begin
         scan_idx = PW'((int'(ptr) + k) % N);
         if (!found && elig[scan_idx]) begin
            found = 1'b1;
            win   = scan_idx;
         end
      end

      arb = (state == IDLE) || !holder_cyc || timeout_hit;

      if (arb) begin
         stall_nx = '0;
         gnt_nx   = '0;
         if (found) begin
            state_nx    = GRANTED;
            g_nx        = win;
            ptr_nx      = (win == PW'(N - 1)) ? '0 : win + PW'(1);
            gnt_nx[win] = 1'b1;
         end else begin
            state_nx = IDLE;
         end
      end else if (holder_stb) begin
         stall_nx = '0;
      end else if (TIMEOUT != 0) begin
         stall_nx = stall_cnt + CW'(1);
      end
   end

   // Outputs: mux the granted source to the sink and return ack to it alone.
   always_comb begin
      bus.s_cyc_o = 1'b0;
      bus.s_stb_o = 1'b0;
      bus.s_dat_o = '0;
      bus.s_tgc_o = '0;
      bus.m_ack_o = '0;
      if (state == GRANTED) begin
         bus.s_cyc_o    = holder_cyc;
         bus.s_stb_o    = holder_stb;
         bus.s_dat_o    = bus.m_dat_i[g*DATA_WIDTH +: DATA_WIDTH];
         bus.s_tgc_o    = bus.m_tgc_i[g*TGC_WIDTH +: TGC_WIDTH];
         bus.m_ack_o[g] = bus.s_ack_i & holder_stb & holder_cyc;
      end
   end
endmodule
